// File: rtl/issue_queue_flush_index_returner.sv
// Hands issue-queue entry indices freed by a selective flush back to the free list,
// RETURN_WIDTH slots per accepted cycle, walking fixed ascending slot groups.
module issue_queue_flush_index_returner #(
  parameter int ENTRY_NUM    = 16,
  parameter int RETURN_WIDTH = 2,
  parameter int INDEX_WIDTH  = $clog2(ENTRY_NUM),
  parameter int GROUP_NUM    = (ENTRY_NUM - 1) / RETURN_WIDTH + 1
) (
  input  logic                                clk,
  input  logic                                rstN,
  input  logic                                flushReq,
  input  logic [ENTRY_NUM-1:0]                flushMask,
  input  logic                                retReady,
  output logic                                busy,
  output logic [RETURN_WIDTH-1:0]             retValid,
  output logic [RETURN_WIDTH*INDEX_WIDTH-1:0] retIndex,
  output logic                                done,
  output logic [INDEX_WIDTH:0]                returnedCount
);

  localparam int SLOT_NUM = GROUP_NUM * RETURN_WIDTH;
  localparam int SLOT_W   = $clog2(SLOT_NUM + 1);
  localparam int CUR_W    = (GROUP_NUM > 1) ? $clog2(GROUP_NUM) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [ENTRY_NUM-1:0]     r_mask;
  logic [CUR_W-1:0]         r_cursor;
  logic [INDEX_WIDTH:0]     r_count;

  logic                     w_in_scan;
  logic                     w_accept;
  logic                     w_last_group;
  logic [SLOT_NUM-1:0]      w_mask_pad;
  logic [RETURN_WIDTH-1:0]  w_groups [GROUP_NUM];
  logic [RETURN_WIDTH-1:0]  w_valid;
  logic [INDEX_WIDTH:0]     w_pop;

  assign w_in_scan    = (r_state == S_SCAN);
  assign w_accept     = w_in_scan && retReady;
  assign w_last_group = (r_cursor == CUR_W'(GROUP_NUM - 1));

  // Pad the mask out to whole groups so slots past the last entry read as released=0.
  always_comb begin
    w_mask_pad                  = '0;
    w_mask_pad[ENTRY_NUM-1:0]   = r_mask;
  end

  genvar gi;
  generate
    for (gi = 0; gi < GROUP_NUM; gi++) begin : g_group
      assign w_groups[gi] = w_mask_pad[gi*RETURN_WIDTH +: RETURN_WIDTH];
    end

    for (gi = 0; gi < RETURN_WIDTH; gi++) begin : g_port
      logic [SLOT_W-1:0] w_slot;
      logic              w_in_range;
      assign w_slot     = SLOT_W'(r_cursor) * SLOT_W'(RETURN_WIDTH) + SLOT_W'(gi);
      assign w_in_range = (w_slot < SLOT_W'(ENTRY_NUM));
      assign w_valid[gi] = w_in_scan && w_groups[r_cursor][gi];
      assign retIndex[gi*INDEX_WIDTH +: INDEX_WIDTH] =
        (w_in_scan && w_in_range) ? w_slot[INDEX_WIDTH-1:0] : '0;
    end
  endgenerate

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < RETURN_WIDTH; k++) begin
      w_pop = w_pop + (INDEX_WIDTH + 1)'(w_valid[k]);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (flushReq) w_state_next = S_SCAN;
      S_SCAN:  if (w_accept && w_last_group) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Mask is only captured from IDLE, so a request during SCAN/DONE cannot disturb it.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_mask   <= '0;
      r_cursor <= '0;
      r_count  <= '0;
    end else if (r_state == S_IDLE) begin
      if (flushReq) begin
        r_mask   <= flushMask;
        r_cursor <= '0;
        r_count  <= '0;
      end
    end else if (w_accept) begin
      r_count <= r_count + w_pop;
      if (!w_last_group) begin
        r_cursor <= r_cursor + CUR_W'(1);
      end
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign retValid      = w_valid;
  assign returnedCount = r_count;

endmodule

// File: tb/tb_issue_queue_flush_index_returner.sv
// Bench for issue_queue_flush_index_returner: 16-entry instance driven by a vector table,
// hand sequences and random flushes; a 5-entry instance covers the partial last group.
module tb_issue_queue_flush_index_returner;

  logic        clk = 1'b0;
  logic        rstN;
  logic        flushReq;
  logic [15:0] flushMask;
  logic        retReady;
  logic        busy;
  logic [1:0]  retValid;
  logic [7:0]  retIndex;
  logic        done;
  logic [4:0]  returnedCount;

  logic        flushReq5;
  logic [4:0]  flushMask5;
  logic        retReady5;
  logic        busy5;
  logic [1:0]  retValid5;
  logic [5:0]  retIndex5;
  logic        done5;
  logic [3:0]  returnedCount5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  issue_queue_flush_index_returner dut16 (
    .clk(clk), .rstN(rstN), .flushReq(flushReq), .flushMask(flushMask),
    .retReady(retReady), .busy(busy), .retValid(retValid), .retIndex(retIndex),
    .done(done), .returnedCount(returnedCount)
  );

  issue_queue_flush_index_returner #(.ENTRY_NUM(5), .RETURN_WIDTH(2)) dut5 (
    .clk(clk), .rstN(rstN), .flushReq(flushReq5), .flushMask(flushMask5),
    .retReady(retReady5), .busy(busy5), .retValid(retValid5), .retIndex(retIndex5),
    .done(done5), .returnedCount(returnedCount5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] mask;
    logic [7:0]  stall_grp;
    int          exp_count;
  } vec_t;

  // One flush on the 16-entry instance. Expected outputs come from the slot rule:
  // group g, port k covers entry g*2+k and is valid iff that mask bit is set.
  // Called at a negedge with the DUT idle. exp_count < 0 means use the model count.
  task automatic run_flush(input string name, input logic [15:0] mask,
                           input logic [7:0] stall_grp, input bit rand_ready,
                           input int exp_count);
    int g, cnt, cyc, slot, want_count;
    bit rdy, stalled;
    logic [1:0] ev;
    logic [7:0] ei;
    int got[$];
    int exp_list[$];
    flushReq  = 1'b1;
    flushMask = mask;
    retReady  = 1'($urandom_range(0, 1));
    @(negedge clk);
    flushReq  = 1'b0;
    flushMask = 16'($urandom);
    g = 0; cnt = 0; cyc = 0; stalled = 1'b0;
    while (g < 8 && cyc < 200) begin
      ev = '0; ei = '0;
      for (int k = 0; k < 2; k++) begin
        slot = g * 2 + k;
        ev[k] = mask[slot];
        ei[k*4 +: 4] = 4'(slot);
      end
      check({name, ".busy"},  32'(busy), 32'd1);
      check({name, ".done"},  32'(done), 32'd0);
      check({name, ".valid"}, 32'(retValid), 32'(ev));
      check({name, ".index"}, 32'(retIndex), 32'(ei));
      check({name, ".count"}, 32'(returnedCount), 32'(cnt));
      if (rand_ready) rdy = ($urandom_range(0, 2) != 0);
      else            rdy = !(stall_grp[g] && !stalled);
      retReady = rdy;
      if (rdy) begin
        for (int k = 0; k < 2; k++) if (retValid[k]) got.push_back(int'(retIndex[k*4 +: 4]));
        cnt += $countones(ev);
        g++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) check({name, ".scan_timeout"}, 32'(cyc), 32'd0);
    want_count = (exp_count < 0) ? cnt : exp_count;
    retReady = 1'($urandom_range(0, 1));
    check({name, ".done_pulse"}, 32'(done), 32'd1);
    check({name, ".done_busy"},  32'(busy), 32'd1);
    check({name, ".done_valid"}, 32'(retValid), 32'd0);
    check({name, ".final_count"}, 32'(returnedCount), 32'(want_count));
    for (int i = 0; i < 16; i++) if (mask[i]) exp_list.push_back(i);
    check({name, ".ret_num"}, 32'(got.size()), 32'(exp_list.size()));
    for (int i = 0; i < exp_list.size() && i < got.size(); i++)
      check({name, ".ret_order"}, 32'(got[i]), 32'(exp_list[i]));
    @(negedge clk);
    check({name, ".idle_busy"},  32'(busy), 32'd0);
    check({name, ".idle_done"},  32'(done), 32'd0);
    check({name, ".idle_count"}, 32'(returnedCount), 32'(want_count));
    retReady = 1'b0;
    $display("flush %s mask=%04h cycles=%0d returned=%0d", name, mask, cyc, got.size());
  endtask

  vec_t vecs[5];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int slot, cnt;
    logic [1:0] ev;
    logic [5:0] ei;

    vecs[0] = '{name: "full",   mask: 16'hFFFF, stall_grp: 8'h00, exp_count: 16};
    vecs[1] = '{name: "sparse", mask: 16'h8021, stall_grp: 8'h04, exp_count: 3};
    vecs[2] = '{name: "empty",  mask: 16'h0000, stall_grp: 8'h00, exp_count: 0};
    vecs[3] = '{name: "odd",    mask: 16'hAAAA, stall_grp: 8'h81, exp_count: 8};
    vecs[4] = '{name: "ends",   mask: 16'h8001, stall_grp: 8'h3C, exp_count: 2};

    rstN = 1'b0; flushReq = 1'b0; flushMask = '0; retReady = 1'b0;
    flushReq5 = 1'b0; flushMask5 = '0; retReady5 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.busy",   32'(busy), 32'd0);
    check("rst.valid",  32'(retValid), 32'd0);
    check("rst.index",  32'(retIndex), 32'd0);
    check("rst.done",   32'(done), 32'd0);
    check("rst.count",  32'(returnedCount), 32'd0);
    check("rst5.busy",  32'(busy5), 32'd0);
    check("rst5.count", 32'(returnedCount5), 32'd0);
    rstN = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_flush(vecs[i].name, vecs[i].mask, vecs[i].stall_grp, 1'b0, vecs[i].exp_count);

    // 5-entry instance: three groups, the last one has only slot 4 in range.
    flushReq5 = 1'b1; flushMask5 = 5'h1F; retReady5 = 1'b1;
    @(negedge clk);
    flushReq5 = 1'b0; flushMask5 = 5'h00;
    cnt = 0;
    for (int g = 0; g < 3; g++) begin
      ev = '0; ei = '0;
      for (int k = 0; k < 2; k++) begin
        slot = g * 2 + k;
        if (slot < 5) begin
          ev[k] = 1'b1;
          ei[k*3 +: 3] = 3'(slot);
        end
      end
      check("e5.busy",  32'(busy5), 32'd1);
      check("e5.valid", 32'(retValid5), 32'(ev));
      check("e5.index", 32'(retIndex5), 32'(ei));
      cnt += $countones(ev);
      @(negedge clk);
    end
    check("e5.done",  32'(done5), 32'd1);
    check("e5.count", 32'(returnedCount5), 32'd5);
    @(negedge clk);
    check("e5.idle", 32'(busy5), 32'd0);
    retReady5 = 1'b0;
    $display("flush e5 mask=1f returned=%0d", cnt);

    // Reset after three accepted groups aborts the scan.
    flushReq = 1'b1; flushMask = 16'hFFFF; retReady = 1'b1;
    @(negedge clk);
    flushReq = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst.pre_count", 32'(returnedCount), 32'd6);
    rstN = 1'b0;
    @(negedge clk);
    check("midrst.busy",  32'(busy), 32'd0);
    check("midrst.valid", 32'(retValid), 32'd0);
    check("midrst.count", 32'(returnedCount), 32'd0);
    rstN = 1'b1; retReady = 1'b0;
    @(negedge clk);
    $display("flush midrst aborted after 3 groups");
    run_flush("after_rst", 16'hFFFF, 8'h00, 1'b0, 16);

    // A request held through DONE is only taken once the block is back in IDLE.
    flushReq = 1'b1; flushMask = 16'h0000; retReady = 1'b1;
    @(negedge clk);
    flushReq = 1'b0;
    repeat (8) @(negedge clk);
    check("donereq.done", 32'(done), 32'd1);
    flushReq = 1'b1; flushMask = 16'h0003;
    @(negedge clk);
    check("donereq.ignored", 32'(busy), 32'd0);
    @(negedge clk);
    flushReq = 1'b0;
    check("donereq.busy",  32'(busy), 32'd1);
    check("donereq.valid", 32'(retValid), 32'd3);
    check("donereq.index", 32'(retIndex), 32'h10);
    repeat (8) @(negedge clk);
    check("donereq.count", 32'(returnedCount), 32'd2);
    @(negedge clk);
    retReady = 1'b0;
    $display("flush donereq mask=0003 returned=2");

    for (int r = 0; r < 25; r++) run_flush("rand", 16'($urandom), 8'h00, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
